// File: rtl/squeeze_dump_stage_if.sv
// Handshake and data bus of the SHAKE squeeze/dump stage.
// slave: the dump stage itself; master: whoever drives jobs, blocks and sinks words.
interface squeeze_dump_stage_if #(
  parameter int unsigned W        = 64,
  parameter int unsigned RATE_MAX = 1344
);
  logic                job_valid;
  logic                job_ready;
  logic [1:0]          operation_mode;
  logic [31:0]         output_size;
  logic                block_valid;
  logic                block_ready;
  logic [RATE_MAX-1:0] rate_output;
  logic [W-1:0]        data_out;
  logic                data_out_valid;
  logic                data_out_ready;
  logic                more_blocks;
  logic                job_done;

  modport slave (
    input  job_valid, operation_mode, output_size, block_valid, rate_output, data_out_ready,
    output job_ready, block_ready, data_out, data_out_valid, more_blocks, job_done
  );

  modport master (
    output job_valid, operation_mode, output_size, block_valid, rate_output, data_out_ready,
    input  job_ready, block_ready, data_out, data_out_valid, more_blocks, job_done
  );
endinterface

// File: rtl/squeeze_dump_stage.sv
// Final SHAKE pipeline stage: serializes the permuted rate into big-endian
// w-bit words and requests further squeezes until output_size bits are emitted.
// Optional build macro DUMP_TAIL_MASK_EN zeroes the unused tail of the final word.
module squeeze_dump_stage #(
  parameter int unsigned W        = 64,
  parameter int unsigned RATE_MAX = 1344
) (
  input  logic                 clk,
  input  logic                 rst,
  squeeze_dump_stage_if.slave  bus
);
  localparam int unsigned LANES  = RATE_MAX / W;
  localparam int unsigned CNT_W  = 27;
  localparam int unsigned IDX_W  = 5;
  localparam logic [1:0]  SHAKE256_MODE_VEC = 2'd1;
  localparam logic [IDX_W-1:0] WPB_128 = IDX_W'(21);
  localparam logic [IDX_W-1:0] WPB_256 = IDX_W'(17);

  typedef enum logic [1:0] {IDLE, WAIT_BLOCK, DUMP} state_t;

  state_t           state_q, state_d;
  logic             mode256_q, mode256_d;
  logic [CNT_W-1:0] words_left_q, words_left_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     data_out_q, data_out_d;
  logic             dov_q, dov_d;
  logic             job_ready_q, job_ready_d;
  logic             block_ready_q, block_ready_d;
  logic             job_done_q, job_done_d;
  logic             load_block_c;
  logic [W-1:0]     piso [LANES];
  logic [IDX_W-1:0] wpb_c;
  logic [W-1:0]     next_lane_c;
  logic [W-1:0]     masked_lane_c;
  logic             more_blocks_c;

  // Little-endian lane to big-endian output word.
  function automatic logic [W-1:0] endian_switch(input logic [W-1:0] x);
    logic [W-1:0] y;
    for (int unsigned b = 0; b < W/8; b++) y[8*b +: 8] = x[W-8-8*b +: 8];
    return y;
  endfunction

  assign wpb_c = mode256_q ? WPB_256 : WPB_128;

  // Lane that will be presented on the next output update.
  always_comb begin
    next_lane_c = piso[IDX_W'(idx_q + IDX_W'(1))];
    if (state_q == WAIT_BLOCK) next_lane_c = bus.rate_output[W-1:0];
  end

`ifdef DUMP_TAIL_MASK_EN
  logic [5:0] rem_q;
  logic       next_last_c;

  // Remaining bit count of the final word, latched with the job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  rem_q <= '0;
    else if (state_q == IDLE && bus.job_valid) rem_q <= bus.output_size[5:0];
  end

  // Keep only the first rem_q bits (lane LSB-first) of the final word.
  always_comb begin
    next_last_c   = (state_q == WAIT_BLOCK) ? (words_left_q == CNT_W'(1))
                                            : (words_left_q == CNT_W'(2));
    masked_lane_c = next_lane_c;
    if (next_last_c && rem_q != 6'd0)
      masked_lane_c = next_lane_c & ((W'(1) << rem_q) - W'(1));
  end
`else
  assign masked_lane_c = next_lane_c;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mode256_q     <= 1'b0;
      words_left_q  <= '0;
      idx_q         <= '0;
      data_out_q    <= '0;
      dov_q         <= 1'b0;
      job_ready_q   <= 1'b1;
      block_ready_q <= 1'b0;
      job_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode256_q     <= mode256_d;
      words_left_q  <= words_left_d;
      idx_q         <= idx_d;
      data_out_q    <= data_out_d;
      dov_q         <= dov_d;
      job_ready_q   <= job_ready_d;
      block_ready_q <= block_ready_d;
      job_done_q    <= job_done_d;
    end
  end

  // PISO capture of the rate lanes on block handshake.
  always_ff @(posedge clk) begin
    if (load_block_c)
      for (int unsigned i = 0; i < LANES; i++) piso[i] <= bus.rate_output[i*W +: W];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    mode256_d     = mode256_q;
    words_left_d  = words_left_q;
    idx_d         = idx_q;
    data_out_d    = data_out_q;
    dov_d         = dov_q;
    job_ready_d   = job_ready_q;
    block_ready_d = block_ready_q;
    job_done_d    = 1'b0;
    load_block_c  = 1'b0;
    case (state_q)
      IDLE: begin
        job_ready_d = 1'b1;
        if (bus.job_valid && job_ready_q) begin
          mode256_d    = (bus.operation_mode == SHAKE256_MODE_VEC);
          words_left_d = CNT_W'((33'(bus.output_size) + 33'd63) >> 6);
          if (bus.output_size == 32'd0) begin
            job_done_d = 1'b1;
          end else begin
            state_d       = WAIT_BLOCK;
            job_ready_d   = 1'b0;
            block_ready_d = 1'b1;
          end
        end
      end
      WAIT_BLOCK: begin
        if (bus.block_valid && block_ready_q) begin
          load_block_c  = 1'b1;
          idx_d         = '0;
          state_d       = DUMP;
          block_ready_d = 1'b0;
          dov_d         = 1'b1;
          data_out_d    = endian_switch(masked_lane_c);
        end
      end
      DUMP: begin
        if (dov_q && bus.data_out_ready) begin
          words_left_d = words_left_q - CNT_W'(1);
          idx_d        = idx_q + IDX_W'(1);
          if (words_left_q == CNT_W'(1)) begin
            state_d     = IDLE;
            dov_d       = 1'b0;
            data_out_d  = '0;
            idx_d       = '0;
            job_done_d  = 1'b1;
            job_ready_d = 1'b1;
          end else if (idx_q == wpb_c - IDX_W'(1)) begin
            state_d       = WAIT_BLOCK;
            dov_d         = 1'b0;
            data_out_d    = '0;
            block_ready_d = 1'b1;
          end else begin
            data_out_d = endian_switch(masked_lane_c);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Squeeze-again request derived from registered state.
  always_comb begin
    more_blocks_c = 1'b0;
    if (state_q == WAIT_BLOCK) more_blocks_c = 1'b1;
    else if (state_q == DUMP)
      more_blocks_c = words_left_q > (CNT_W'(wpb_c) - CNT_W'(idx_q));
  end

  assign bus.job_ready      = job_ready_q;
  assign bus.block_ready    = block_ready_q;
  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = dov_q;
  assign bus.job_done       = job_done_q;
  assign bus.more_blocks    = more_blocks_c;
endmodule
